// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes a MIPS instruction plus operands into {ALUControl, A, B}
// and issues it through a 2-entry valid/ready skid buffer toward EX.
// Ports: Clk, Reset_n (async, active-low), Flush; InValid/InReady, Instr,
//   RsData, RtData in; OutValid/OutReady, ALUControl, A, B, IssueCount out.
// Optional macro ALU_ILLEGAL_TRAP_EN adds sticky IllegalOp output.
module alu_op_issue #(
    parameter int SHAMT_W = 5,
    parameter int DEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [4:0]  ALUControl,
    output logic [31:0] A,
    output logic [31:0] B,
`ifdef ALU_ILLEGAL_TRAP_EN
    output logic        IllegalOp,
`endif
    output logic [15:0] IssueCount
);

    localparam logic [4:0] C_NONE = 5'b00000, C_ADD = 5'b00001;
    localparam logic [4:0] C_SUB  = 5'b00010, C_MUL = 5'b00011;
    localparam logic [4:0] C_SLL  = 5'b00100, C_SRL = 5'b00101;
    localparam logic [4:0] C_AND  = 5'b00110, C_OR  = 5'b00111;
    localparam logic [4:0] C_XOR  = 5'b01000, C_BGEZ = 5'b01011;
    localparam logic [4:0] C_BEQ  = 5'b01100, C_NOR = 5'b01101;
    localparam logic [4:0] C_SLT  = 5'b01110, C_BNE = 5'b01111;
    localparam logic [4:0] C_BGTZ = 5'b10000, C_BLEZ = 5'b10001;
    localparam logic [4:0] C_BLTZ = 5'b10010;

    logic [5:0]  op, fn;
    logic [4:0]  rt_f;
    logic [31:0] sext, zext, shamt, rs_sh;
    logic [4:0]  dec_c;
    logic [31:0] dec_a, dec_b;

    assign op    = Instr[31:26];
    assign fn    = Instr[5:0];
    assign rt_f  = Instr[20:16];
    assign sext  = {{16{Instr[15]}}, Instr[15:0]};
    assign zext  = {16'h0000, Instr[15:0]};
    assign shamt = {{(32-SHAMT_W){1'b0}}, Instr[6 +: SHAMT_W]};
    assign rs_sh = {{(32-SHAMT_W){1'b0}}, RsData[SHAMT_W-1:0]};

    // Illegal encodings fall through with all-zero op/operands.
    always_comb begin
        dec_c = C_NONE;
        dec_a = '0;
        dec_b = '0;
        unique case (op)
            6'h00: begin
                dec_a = RsData;
                dec_b = RtData;
                unique case (fn)
                    6'h20, 6'h21: dec_c = C_ADD;
                    6'h22:        dec_c = C_SUB;
                    6'h24:        dec_c = C_AND;
                    6'h25:        dec_c = C_OR;
                    6'h26:        dec_c = C_XOR;
                    6'h27:        dec_c = C_NOR;
                    6'h2A:        dec_c = C_SLT;
                    6'h00, 6'h02: begin
                        dec_c = (fn == 6'h00) ? C_SLL : C_SRL;
                        dec_a = RtData;
                        dec_b = shamt;
                    end
                    6'h04, 6'h06: begin
                        dec_c = (fn == 6'h04) ? C_SLL : C_SRL;
                        dec_a = RtData;
                        dec_b = rs_sh;
                    end
                    default: begin
                        dec_a = '0;
                        dec_b = '0;
                    end
                endcase
            end
            6'h1C: if (fn == 6'h02) begin
                dec_c = C_MUL;
                dec_a = RsData;
                dec_b = RtData;
            end
            6'h08, 6'h09, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: begin
                dec_c = C_ADD;
                dec_a = RsData;
                dec_b = sext;
            end
            6'h0A: begin
                dec_c = C_SLT;
                dec_a = RsData;
                dec_b = sext;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_c = (op == 6'h0C) ? C_AND :
                        (op == 6'h0D) ? C_OR : C_XOR;
                dec_a = RsData;
                dec_b = zext;
            end
            6'h0F: begin
                dec_c = C_SLL;
                dec_a = zext;
                dec_b = 32'd16;
            end
            6'h04, 6'h05: begin
                dec_c = (op == 6'h04) ? C_BEQ : C_BNE;
                dec_a = RsData;
                dec_b = RtData;
            end
            6'h06, 6'h07: begin
                dec_c = (op == 6'h07) ? C_BGTZ : C_BLEZ;
                dec_a = RsData;
            end
            6'h01: begin
                if (rt_f == 5'd1) begin
                    dec_c = C_BGEZ;
                    dec_a = RsData;
                end else if (rt_f == 5'd0) begin
                    dec_c = C_BLTZ;
                    dec_a = RsData;
                end
            end
            default: dec_c = C_NONE;
        endcase
    end

    logic [1:0]  cnt_q, cnt_d;
    logic        vld_q, rdy_q;
    logic [4:0]  c_q, sc_q;
    logic [31:0] a_q, b_q, sa_q, sb_q;
    logic [15:0] iss_q;
    logic        acc, pop, ld_main, ld_skid, mv_skid;

    assign acc = InValid & rdy_q;
    assign pop = vld_q & OutReady;

    always_comb begin
        cnt_d   = cnt_q;
        ld_main = 1'b0;
        ld_skid = 1'b0;
        mv_skid = 1'b0;
        if (Flush) begin
            cnt_d = 2'd0;
        end else begin
            unique case (cnt_q)
                2'd0: if (acc) begin
                    cnt_d   = 2'd1;
                    ld_main = 1'b1;
                end
                2'd1: begin
                    if (acc && pop) begin
                        ld_main = 1'b1;
                    end else if (acc) begin
                        cnt_d   = 2'd2;
                        ld_skid = 1'b1;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end
                end
                2'd2: if (pop) begin
                    cnt_d   = 2'd1;
                    mv_skid = 1'b1;
                end
                default: cnt_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= 2'd0;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sc_q  <= '0;
            sa_q  <= '0;
            sb_q  <= '0;
            iss_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= (cnt_d != 2'd0);
            rdy_q <= (int'(cnt_d) < DEPTH);
            if (pop) iss_q <= iss_q + 16'd1;
            if (ld_main) begin
                c_q <= dec_c;
                a_q <= dec_a;
                b_q <= dec_b;
            end else if (mv_skid) begin
                c_q <= sc_q;
                a_q <= sa_q;
                b_q <= sb_q;
            end
            if (ld_skid) begin
                sc_q <= dec_c;
                sa_q <= dec_a;
                sb_q <= dec_b;
            end
        end
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    // Every legal decode yields a nonzero op code.
    logic ill_q;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            ill_q <= 1'b0;
        else if (acc && !Flush && dec_c == C_NONE)
            ill_q <= 1'b1;
    end
    assign IllegalOp = ill_q;
`endif

    assign InReady    = rdy_q;
    assign OutValid   = vld_q;
    assign ALUControl = c_q;
    assign A          = a_q;
    assign B          = b_q;
    assign IssueCount = iss_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed vector table, stall/flush/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_alu_op_issue;

    logic        Clk = 0, Reset_n = 0, Flush = 0, InValid = 0, OutReady = 0;
    logic        InReady, OutValid;
    logic [31:0] Instr = 0, RsData = 0, RtData = 0, A, B;
    logic [4:0]  ALUControl;
    logic [15:0] IssueCount;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic        IllegalOp;
`endif

    alu_op_issue dut (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .Instr(Instr),
        .RsData(RsData), .RtData(RtData), .OutValid(OutValid),
        .OutReady(OutReady), .ALUControl(ALUControl), .A(A), .B(B),
`ifdef ALU_ILLEGAL_TRAP_EN
        .IllegalOp(IllegalOp),
`endif
        .IssueCount(IssueCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    int checks = 0, errors = 0;
    op_t q[$];
    logic [15:0] m_iss = 0;
    logic m_ill = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input int c, input logic [31:0] a, input logic [31:0] b);
        op_t r;
        r.c = c[4:0];
        r.a = a;
        r.b = b;
        return r;
    endfunction

    // Reference decode written straight from the instruction table.
    function automatic op_t ref_dec(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt);
        int op, fn, rtf;
        logic [31:0] se, ze, sh;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        rtf = int'(ins[20:16]);
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        sh  = {27'h0, ins[10:6]};
        if (op == 0) begin
            if (fn == 'h20 || fn == 'h21) return mk(1, rs, rt);
            if (fn == 'h22) return mk(2, rs, rt);
            if (fn == 'h24) return mk(6, rs, rt);
            if (fn == 'h25) return mk(7, rs, rt);
            if (fn == 'h26) return mk(8, rs, rt);
            if (fn == 'h27) return mk(13, rs, rt);
            if (fn == 'h2A) return mk(14, rs, rt);
            if (fn == 'h00) return mk(4, rt, sh);
            if (fn == 'h02) return mk(5, rt, sh);
            if (fn == 'h04) return mk(4, rt, rs % 32);
            if (fn == 'h06) return mk(5, rt, rs % 32);
            return mk(0, 0, 0);
        end
        if (op == 'h1C && fn == 2) return mk(3, rs, rt);
        if (op inside {'h08, 'h09, 'h20, 'h21, 'h23, 'h28, 'h29, 'h2B})
            return mk(1, rs, se);
        if (op == 'h0A) return mk(14, rs, se);
        if (op == 'h0C) return mk(6, rs, ze);
        if (op == 'h0D) return mk(7, rs, ze);
        if (op == 'h0E) return mk(8, rs, ze);
        if (op == 'h0F) return mk(4, ze, 16);
        if (op == 'h04) return mk(12, rs, rt);
        if (op == 'h05) return mk(15, rs, rt);
        if (op == 'h07) return mk(16, rs, 0);
        if (op == 'h06) return mk(17, rs, 0);
        if (op == 'h01 && rtf == 1) return mk(11, rs, 0);
        if (op == 'h01 && rtf == 0) return mk(18, rs, 0);
        return mk(0, 0, 0);
    endfunction

    task automatic check_model();
        chk("OutValid", 32'(OutValid), 32'(q.size() > 0));
        chk("InReady", 32'(InReady), 32'(q.size() < 2));
        chk("IssueCount", 32'(IssueCount), 32'(m_iss));
        if (q.size() > 0) begin
            chk("ALUControl", 32'(ALUControl), 32'(q[0].c));
            chk("A", A, q[0].a);
            chk("B", B, q[0].b);
        end
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("IllegalOp", 32'(IllegalOp), 32'(m_ill));
`endif
    endtask

    // One clock: model follows FIFO rules, then outputs are compared.
    task automatic step();
        bit acc, pop;
        op_t d;
        acc = InValid && (q.size() < 2);
        pop = (q.size() > 0) && OutReady;
        d   = ref_dec(Instr, RsData, RtData);
        @(posedge Clk);
        if (pop) begin
            void'(q.pop_front());
            m_iss = m_iss + 16'd1;
        end
        if (Flush) q.delete();
        else if (acc) begin
            q.push_back(d);
            if (d.c == 5'd0) m_ill = 1;
        end
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset_n = 0;
        InValid = 0;
        Flush = 0;
        q.delete();
        m_iss = 0;
        m_ill = 0;
        #1;
        chk("rst OutValid", 32'(OutValid), 0);
        chk("rst ALUControl", 32'(ALUControl), 0);
        chk("rst A", A, 0);
        chk("rst B", B, 0);
        chk("rst IssueCount", 32'(IssueCount), 0);
        @(negedge Clk);
        Reset_n = 1;
        @(posedge Clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic [31:0] ins, rs, rt;
        logic [4:0]  c;
        logic [31:0] a, b;
    } vec_t;

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int ops[20] = '{0, 0, 0, 1, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14, 15,
                        'h1C, 'h20, 'h23, 'h2B, 'h3F};
        int fns[12] = '{0, 2, 4, 6, 'h20, 'h21, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A};
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        w[31:26] = 6'(ops[$urandom_range(0, 19)]);
        if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
            w[5:0] = 6'(fns[$urandom_range(0, 11)]);
        if (w[31:26] == 6'h1C && $urandom_range(0, 3) != 0) w[5:0] = 6'h02;
        if (w[31:26] == 6'h01) w[20:16] = 5'($urandom_range(0, 2));
        return w;
    endfunction

    vec_t vt[14];

    initial begin
        vt[0]  = '{32'h00221820, 5, 7, 5'h01, 5, 7};
        vt[1]  = '{32'h2022FFFC, 10, 3, 5'h01, 10, 32'hFFFFFFFC};
        vt[2]  = '{32'h34228000, 3, 9, 5'h07, 3, 32'h00008000};
        vt[3]  = '{32'h00011100, 9, 1, 5'h04, 1, 4};
        vt[4]  = '{32'h3C011234, 8, 8, 5'h04, 32'h1234, 16};
        vt[5]  = '{32'h04200010, 32'hFFFFFFFD, 2, 5'h12, 32'hFFFFFFFD, 0};
        vt[6]  = '{32'hFC000000, 6, 6, 5'h00, 0, 0};
        vt[7]  = '{32'h00221822, 9, 4, 5'h02, 9, 4};
        vt[8]  = '{32'h70221002, 11, 12, 5'h03, 11, 12};
        vt[9]  = '{32'h00221004, 32'h25, 8, 5'h04, 8, 5};
        vt[10] = '{32'h04210005, 77, 1, 5'h0B, 77, 0};
        vt[11] = '{32'h2822FFFF, 3, 0, 5'h0E, 3, 32'hFFFFFFFF};
        vt[12] = '{32'h10220003, 1, 2, 5'h0C, 1, 2};
        vt[13] = '{32'h00221827, 32'hF0, 32'h0F, 5'h0D, 32'hF0, 32'h0F};

        do_reset();
        chk("rst InReady", 32'(InReady), 1);

        // Directed vector table, streaming with EX always ready.
        OutReady = 1;
        InValid  = 1;
        for (int i = 0; i < 14; i++) begin
            Instr  = vt[i].ins;
            RsData = vt[i].rs;
            RtData = vt[i].rt;
            step();
            chk($sformatf("vec%0d ctl", i), 32'(ALUControl), 32'(vt[i].c));
            chk($sformatf("vec%0d A", i), A, vt[i].a);
            chk($sformatf("vec%0d B", i), B, vt[i].b);
        end
        InValid = 0;
        step();

        // Three ops into a stalled EX, then drain in order.
        do_reset();
        OutReady = 0;
        InValid  = 1;
        Instr = 32'h00221820; RsData = 1; RtData = 1;
        step();
        Instr = 32'h00221822; RsData = 2; RtData = 2;
        step();
        chk("stall InReady", 32'(InReady), 0);
        Instr = 32'h00221824; RsData = 3; RtData = 3;
        step();
        chk("stall hold ctl", 32'(ALUControl), 1);
        chk("stall hold A", A, 1);
        OutReady = 1;
        step();
        chk("drain2 ctl", 32'(ALUControl), 2);
        step();
        chk("drain3 ctl", 32'(ALUControl), 6);
        chk("drain3 A", A, 3);
        InValid = 0;
        step();
        chk("issued 3", 32'(IssueCount), 3);
        chk("drained", 32'(OutValid), 0);

        // Flush while full with a concurrent input.
        do_reset();
        OutReady = 0;
        InValid  = 1;
        Instr = 32'h00221820; RsData = 4; RtData = 4;
        step();
        step();
        Flush = 1;
        step();
        chk("flush OutValid", 32'(OutValid), 0);
        chk("flush InReady", 32'(InReady), 1);
        Flush = 0;
        InValid = 0;
        OutReady = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post-flush idle", 32'(OutValid), 0);
        end

        // Reset mid-stall, then an illegal op.
        OutReady = 0;
        InValid  = 1;
        Instr = 32'h3C01ABCD;
        step();
        step();
        do_reset();
        OutReady = 1;
        InValid  = 1;
        Instr = 32'hFC000000; RsData = 32'hDEAD; RtData = 32'hBEEF;
        step();
        chk("illegal ctl", 32'(ALUControl), 0);
        chk("illegal A", A, 0);
        chk("illegal B", B, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("illegal sticky", 32'(IllegalOp), 1);
`endif
        InValid = 0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            InValid  = ($urandom_range(0, 9) < 7);
            OutReady = ($urandom_range(0, 9) < 6);
            Flush    = ($urandom_range(0, 39) == 0);
            Instr    = rnd_instr();
            RsData   = $urandom;
            RtData   = $urandom;
            step();
        end
        Flush = 0;
        InValid = 0;
        OutReady = 1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
